picosoc_bus_xbar: RTL and testbench
===================================

# picosoc_bus_xbar

Parametrised single-master address decoder and response mux for the PicoSoC memory bus, placed between the PicoRV32 native memory port and NSLV slaves (RAM, ROM, SPI flash, UART, external iomem). Generalises the hard-wired per-peripheral select/ready/rdata chain into a table of base/mask regions. Adds:
- a registered request/response handshake
- an unmapped-address error response
- an optional per-access timeout, with a bus-error interrupt and a captured fault address.

## Interface
Parameters:
- NSLV, 4: number of slave channels, 1..16.
- SLV_BASE, {NSLV{32'h0}}: packed NSLV×32 region bases; slave i base in bits [32i+31:32i].
- SLV_MASK, {NSLV{32'hFFFF_FFFF}}: packed NSLV×32 masks; slave i matches when (mem_addr & mask_i) == base_i.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on error responses.
- TIMEOUT, 255: cycles allowed in REQ before abort, 1..65535 (used only with PICOSOC_BUS_TIMEOUT_EN).

Ports. Clock and reset: one clock; reset is synchronous and active-low.
- clk, in, 1: system clock.
- resetn, in, 1: synchronous active-low reset.

Master port:
- mem_valid, in, 1: CPU request valid.
- mem_ready, out, 1: one-cycle response strobe.
- mem_addr, in, 32: request address.
- mem_wdata, in, 32: write data.
- mem_wstrb, in, 4: byte write strobes; 0 means read.
- mem_rdata, out, 32: read data.

Slave ports:
- s_valid, out, NSLV: one-hot request to the selected slave.
- s_ready, in, NSLV: per-slave completion.
- s_rdata, in, NSLV×32: packed per-slave read data.
- s_addr, out, 32: registered copy of mem_addr.
- s_wdata, out, 32: registered copy of mem_wdata.
- s_wstrb, out, 4: registered copy of mem_wstrb.

Error reporting:
- irq_buserr, out, 1: one-cycle pulse on an error response.
- err_addr, out, 32: address of the most recent faulting access.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Waits for mem_valid.
  - Decodes mem_addr against all regions; on overlap the lowest index wins.
  - Latches sel, mem_addr, mem_wdata and mem_wstrb into s_addr, s_wdata and s_wstrb.
  - On a hit: go to REQ with s_valid[sel]=1.
  - On a miss: go to RESP with rdata_q=ERR_DATA and err_q=1.
- REQ:
  - s_valid[sel] is held high and the timeout counter increments.
  - On s_ready[sel]: rdata_q captures s_rdata[sel], s_valid clears, go to RESP.
  - s_ready on any other channel is ignored.
- RESP:
  - mem_ready=1 and mem_rdata=rdata_q for exactly one cycle.
  - irq_buserr=err_q; when err_q=1, err_addr is loaded from s_addr.
  - Always returns to IDLE.
- On error writes, the write is dropped and no slave sees the request.
- mem_rdata is driven from rdata_q at all times; it is meaningful only while mem_ready=1.
- Reset values: mem_ready=0, s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, mem_rdata=0, irq_buserr=0, err_addr=0, state=IDLE, counter=0.
- Reset in REQ: s_valid drops on the next edge and no response is issued.

## Timing
- Mapped access latency: mem_valid is sampled at edge N.
  - s_valid is high from N+1.
  - s_ready is sampled at edge M.
  - mem_ready is high during cycle M+1.
  - Total 2 cycles plus slave latency.
  - Zero-wait slave (s_ready combinational to s_valid): mem_ready is high during cycle N+2.
- Unmapped access: mem_ready is high during cycle N+1.
- Back-to-back accesses: IDLE is revisited for one cycle between accesses, so one access completes every ≥3 cycles.
- mem_valid is expected to drop after the mem_ready cycle.
  - The CPU must not change its request while waiting.
  - Changes to mem_addr after IDLE are ignored because the request is latched.
- s_rdata is sampled only in the cycle s_ready[sel]=1.

## Configuration
- Macro: PICOSOC_BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit counter is cleared on entry to REQ.
  - When the counter reaches TIMEOUT with no s_ready[sel], s_valid clears, rdata_q=ERR_DATA, err_q=1, and the FSM goes to RESP.
  - If s_ready[sel] arrives on the same edge as the timeout, the slave response wins and no error is raised.
- Undefined:
  - No counter is built.
  - REQ waits indefinitely.
  - Unmapped-address errors remain.

## Test plan
- Read hit, zero-wait slave 1 (base 32'h0002_0000, mask 32'hFFFF_C000, rdata 32'h1234_5678) at 32'h0002_0010 -> mem_ready 2 cycles after mem_valid, mem_rdata=32'h1234_5678, irq_buserr stays 0.
- Write to slave 2 with wstrb=4'b0011, slave ready after 5 cycles -> s_valid[2] high for 6 cycles, s_wstrb=4'b0011, s_wdata matches, mem_ready 7 cycles after mem_valid.
- Regions for slaves 0 and 3 overlap at 32'h0200_0000 -> only s_valid[0] asserts.
- Read of unmapped address 32'h0F00_0000 -> mem_ready next cycle, mem_rdata=32'hDEAD_BEEF, irq_buserr pulses once, err_addr=32'h0F00_0000, s_valid stays 0.
- With PICOSOC_BUS_TIMEOUT_EN and TIMEOUT=8, slave never ready -> abort after 8 REQ cycles, ERR_DATA returned, irq_buserr pulses. A second run with s_ready arriving exactly at the timeout edge -> slave data returned, no irq.
- Assert resetn=0 while in REQ -> s_valid=0 after the next edge, no mem_ready, all outputs at reset values; the next access completes normally.

Source files
------------

// File: rtl/picosoc_bus_xbar.sv
// Single-master address decoder and response mux for the PicoSoC memory bus.
// Define PICOSOC_BUS_TIMEOUT_EN to add a per-access REQ timeout that aborts with a bus error.
module picosoc_bus_xbar #(
    parameter int                 NSLV     = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'hFFFF_FFFF}},
    parameter logic [31:0]        ERR_DATA = 32'hDEAD_BEEF,
    parameter int                 TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic [31:0]          mem_rdata,
    output logic [NSLV-1:0]      s_valid,
    input  logic [NSLV-1:0]      s_ready,
    input  logic [NSLV*32-1:0]   s_rdata,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    output logic                 irq_buserr,
    output logic [31:0]          err_addr
);

    localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    if (NSLV < 1 || NSLV > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("picosoc_bus_xbar: NSLV or TIMEOUT out of range");
    end

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [31:0]        err_addr_q, err_addr_d;

    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               sel_ready;
    logic [31:0]        sel_rdata;

    // Scanning from the top index down lets the lowest matching region win on overlap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        s_valid   = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready  = s_ready[i];
                sel_rdata  = s_rdata[32*i +: 32];
                s_valid[i] = (state_q == REQ);
            end
        end
    end

`ifdef PICOSOC_BUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_hit;

    always_comb begin
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == REQ) begin
            cnt_d       = cnt_q + 16'd1;
            timeout_hit = (cnt_d == 16'(TIMEOUT));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    sel_d   = hit_idx;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    if (hit) begin
                        state_d = REQ;
                        err_d   = 1'b0;
                    end else begin
                        state_d = RESP;
                        rdata_d = ERR_DATA;
                        err_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                // A slave response on the timeout edge still wins over the abort.
                if (sel_ready) begin
                    state_d = RESP;
                    rdata_d = sel_rdata;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                if (err_q) err_addr_d = addr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!resetn) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign mem_ready  = (state_q == RESP);
    assign irq_buserr = (state_q == RESP) && err_q;
    assign mem_rdata  = rdata_q;
    assign s_addr     = addr_q;
    assign s_wdata    = wdata_q;
    assign s_wstrb    = wstrb_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_picosoc_bus_xbar.sv
// Randomised self-checking bench for picosoc_bus_xbar against a transaction-level reference model.
// Timeout scenarios run only when PICOSOC_BUS_TIMEOUT_EN is defined.
module tb_picosoc_bus_xbar;

    localparam int          NSLV = 4;
    localparam int          TO   = 8;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    // Slave 0: 0x0200_xxxx, 1: 0x0002_0000/16K, 2: 0x0300_xxxx, 3: 0x02xx_xxxx (shadowed by 0 where they overlap).
    localparam logic [127:0] BASE = {32'h0200_0000, 32'h0300_0000, 32'h0002_0000, 32'h0200_0000};
    localparam logic [127:0] MASK = {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_C000, 32'hFFFF_0000};
`ifdef PICOSOC_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               resetn;
    logic               mem_valid;
    logic               mem_ready;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;
    logic [3:0]         mem_wstrb;
    logic [NSLV-1:0]    s_valid, s_ready;
    logic [NSLV*32-1:0] s_rdata;
    logic [31:0]        s_addr, s_wdata;
    logic [3:0]         s_wstrb;
    logic               irq_buserr;
    logic [31:0]        err_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_err_addr = '0;

    int          lat      [NSLV];
    logic [31:0] slv_data [NSLV];
    int          wait_cnt [NSLV];
    logic [31:0] garbage  [NSLV];
    logic [NSLV-1:0] noise;

    picosoc_bus_xbar #(
        .NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .ERR_DATA(ERR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .irq_buserr(irq_buserr), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // Slave models: ready after lat[i] extra cycles of valid; idle channels toggle ready/rdata randomly.
    always @(posedge clk) begin
        noise <= NSLV'($urandom);
        for (int i = 0; i < NSLV; i++) begin
            wait_cnt[i] <= s_valid[i] ? wait_cnt[i] + 1 : 0;
            garbage[i]  <= $urandom;
        end
    end

    always_comb begin
        s_ready = '0;
        s_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            s_ready[i]         = s_valid[i] ? (wait_cnt[i] == lat[i]) : noise[i];
            s_rdata[32*i +: 32] = (s_valid[i] && s_ready[i]) ? slv_data[i] : garbage[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NSLV; i++)
            if ((a & MASK[32*i +: 32]) == BASE[32*i +: 32]) return i;
        return -1;
    endfunction

    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int lat_v, input string tag);
        int              sel, exp_lat, exp_sv, cycles, sv_cycles, bad_sv;
        bit              hit, tmo, err, done;
        logic [31:0]     exp_rdata, got_rdata;
        logic            got_irq;
        logic [NSLV-1:0] exp_oh;

        for (int i = 0; i < NSLV; i++) begin
            lat[i]      = lat_v;
            slv_data[i] = $urandom;
        end
        sel       = ref_decode(a);
        hit       = (sel >= 0);
        tmo       = TO_EN && hit && (lat_v + 1 > TO);
        err       = !hit || tmo;
        exp_lat   = !hit ? 1 : (tmo ? TO + 1 : lat_v + 2);
        exp_sv    = !hit ? 0 : (tmo ? TO : lat_v + 1);
        exp_rdata = err ? ERR : slv_data[sel];
        exp_oh    = hit ? NSLV'(1 << sel) : '0;

        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        cycles = 0; sv_cycles = 0; bad_sv = 0; done = 1'b0;
        got_rdata = '0; got_irq = 1'b0;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (s_valid != '0) begin
                sv_cycles++;
                if (s_valid != exp_oh || s_addr != a || s_wdata != wd || s_wstrb != ws) bad_sv++;
            end
            if (mem_ready) begin
                done      = 1'b1;
                got_rdata = mem_rdata;
                got_irq   = irq_buserr;
                mem_valid = 1'b0;
            end else begin
                // The request is latched; later wiggles on the master bus must be ignored.
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
        end
        mem_valid = 1'b0;
        check({tag, "_done"},    32'(done),      32'd1);
        check({tag, "_latency"}, 32'(cycles),    32'(exp_lat));
        check({tag, "_rdata"},   got_rdata,      exp_rdata);
        check({tag, "_irq"},     32'(got_irq),   32'(err));
        check({tag, "_sv_len"},  32'(sv_cycles), 32'(exp_sv));
        check({tag, "_sv_bad"},  32'(bad_sv),    32'd0);
        if (err) exp_err_addr = a;
        @(posedge clk);
        #1;
        check({tag, "_ready_1cyc"}, 32'(mem_ready),  32'd0);
        check({tag, "_irq_1cyc"},   32'(irq_buserr), 32'd0);
        check({tag, "_err_addr"},   err_addr,        exp_err_addr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_ready"}, 32'(mem_ready),  32'd0);
        check({tag, "_s_valid"},   32'(s_valid),    32'd0);
        check({tag, "_s_addr"},    s_addr,          32'd0);
        check({tag, "_s_wdata"},   s_wdata,         32'd0);
        check({tag, "_s_wstrb"},   32'(s_wstrb),    32'd0);
        check({tag, "_mem_rdata"}, mem_rdata,       32'd0);
        check({tag, "_irq"},       32'(irq_buserr), 32'd0);
        check({tag, "_err_addr"},  err_addr,        32'd0);
    endtask

    initial begin
        int          kind, seen_ready, waited;
        logic [31:0] a;

        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        for (int i = 0; i < NSLV; i++) begin
            lat[i] = 0; slv_data[i] = '0; wait_cnt[i] = 0; garbage[i] = '0;
        end
        noise = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        resetn = 1'b1;

        do_txn(32'h0002_0010, 32'h0,         4'b0000, 0, "rd_s1_zero_wait");
        do_txn(32'h0300_0100, 32'hA5A5_1234, 4'b0011, 5, "wr_s2_lat5");
        do_txn(32'h0200_0000, 32'h0,         4'b0000, 2, "overlap_s0");
        do_txn(32'h0201_0040, 32'h1111_2222, 4'b1111, 1, "s3_only");
        do_txn(32'h0F00_0000, 32'h0,         4'b0000, 0, "unmapped_rd");
        do_txn(32'h0F00_0004, 32'hCAFE_F00D, 4'b1111, 0, "unmapped_wr");
`ifdef PICOSOC_BUS_TIMEOUT_EN
        do_txn(32'h0300_0200, 32'h0,         4'b0000, 1000, "timeout_abort");
        do_txn(32'h0300_0204, 32'h0,         4'b0000, TO - 1, "timeout_edge_race");
`endif

        // Reset while the access is parked in REQ.
        for (int i = 0; i < NSLV; i++) lat[i] = 50;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0300_0300; mem_wdata = 32'h5555_AAAA; mem_wstrb = 4'b1111;
        waited = 0;
        while (s_valid == '0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("rst_req_entered", 32'(s_valid), 32'b0100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_in_req");
        exp_err_addr = '0;
        @(negedge clk);
        resetn = 1'b1;
        seen_ready = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mem_ready) seen_ready++;
        end
        check("rst_no_response", 32'(seen_ready), 32'd0);
        do_txn(32'h0300_0300, 32'h0BAD_F00D, 4'b0101, 1, "after_reset");

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0:       a = 32'h0200_0000 | ($urandom & 32'h0000_FFFC);
                1:       a = 32'h0002_0000 | ($urandom & 32'h0000_3FFC);
                2:       a = 32'h0300_0000 | ($urandom & 32'h0000_FFFC);
                3:       a = 32'h0200_0000 | ($urandom & 32'h00FF_FFFC);
                default: a = $urandom;
            endcase
            do_txn(a, $urandom, 4'($urandom), $urandom_range(0, 6), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
